// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: NS main, EW side, pedestrian WALK.
// Ports: clk, rst_n, ped_btn, car_ew in; NS/EW lamps, walk, ped_wait, state_o out.
module intersection_controller #(
  parameter int unsigned GREEN_MIN = 20000000,
  parameter int unsigned GREEN_MAX = 60000000,
  parameter int unsigned YELLOW_T  = 10000000,
  parameter int unsigned ALLRED_T  = 5000000,
  parameter int unsigned WALK_T    = 30000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_btn,
  input  logic       car_ew,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    NSG  = 3'd0,
    NSY  = 3'd1,
    AR_A = 3'd2,
    EWG  = 3'd3,
    EWY  = 3'd4,
    AR_B = 3'd5,
    WALK = 3'd6,
    AR_W = 3'd7
  } state_t;

  localparam logic [31:0] GMIN_M1 = 32'(GREEN_MIN - 1);
  localparam logic [31:0] GMAX_M1 = 32'(GREEN_MAX - 1);
  localparam logic [31:0] YEL_M1  = 32'(YELLOW_T - 1);
  localparam logic [31:0] AR_M1   = 32'(ALLRED_T - 1);
  localparam logic [31:0] WALK_M1 = 32'(WALK_T - 1);

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic        ped_s1;
  logic        ped_s2;
  logic        ped_q;
  logic        car_s1;
  logic        car_s;
  logic        ped_pending;
  logic        ped_edge;
  logic        demand;
  logic        walk_entry;

  assign ped_edge   = ped_s2 & ~ped_q;
  assign demand     = car_s | ped_pending;
  assign walk_entry = (state_n == WALK) && (state != WALK);
  assign ped_wait   = ped_pending;
  assign state_o    = state;

  always_comb begin
    state_n = state;
    case (state)
      AR_B: if (cnt == AR_M1) state_n = NSG;
      NSG:  if (demand && cnt >= GMIN_M1) state_n = NSY;
      NSY:  if (cnt == YEL_M1) state_n = AR_A;
      AR_A: if (cnt == AR_M1) state_n = ped_pending ? WALK : EWG;
      WALK: if (cnt == WALK_M1) state_n = AR_W;
      AR_W: if (cnt == AR_M1) state_n = car_s ? EWG : NSG;
      // gap-out at minimum, max-out at maximum
      EWG:  if (cnt >= GMIN_M1 && (!car_s || cnt == GMAX_M1))
              state_n = EWY;
      EWY:  if (cnt == YEL_M1) state_n = AR_B;
      default: state_n = AR_B;
    endcase
  end

  always_comb begin
    cnt_n = cnt;
    if (state_n != state)
      cnt_n = '0;
    else if (state == NSG && cnt >= GMIN_M1)
      cnt_n = cnt;
    else if (cnt != '1)
      cnt_n = cnt + 32'd1;
  end

  // Lamps are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= AR_B;
      cnt         <= '0;
      ped_s1      <= 1'b0;
      ped_s2      <= 1'b0;
      ped_q       <= 1'b0;
      car_s1      <= 1'b0;
      car_s       <= 1'b0;
      ped_pending <= 1'b0;
      ns_red      <= 1'b1;
      ns_yellow   <= 1'b0;
      ns_green    <= 1'b0;
      ew_red      <= 1'b1;
      ew_yellow   <= 1'b0;
      ew_green    <= 1'b0;
      walk        <= 1'b0;
    end else begin
      ped_s1 <= ped_btn;
      ped_s2 <= ped_s1;
      ped_q  <= ped_s2;
      car_s1 <= car_ew;
      car_s  <= car_s1;
      state  <= state_n;
      cnt    <= cnt_n;
      // clear on WALK entry beats a coincident press
      if (walk_entry)
        ped_pending <= 1'b0;
      else if (ped_edge && state != WALK)
        ped_pending <= 1'b1;
      ns_green  <= (state_n == NSG);
      ns_yellow <= (state_n == NSY);
      ns_red    <= (state_n != NSG) && (state_n != NSY);
      ew_green  <= (state_n == EWG);
      ew_yellow <= (state_n == EWY);
      ew_red    <= (state_n != EWG) && (state_n != EWY);
      walk      <= (state_n == WALK);
    end
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller with small timing parameters.
// Checks phase durations, ped latch, gap/max-out and async reset.
module tb_intersection_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ped_btn;
  logic       car_ew;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       walk, ped_wait;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  intersection_controller #(
    .GREEN_MIN(4),
    .GREEN_MAX(10),
    .YELLOW_T (3),
    .ALLRED_T (2),
    .WALK_T   (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ped_btn  (ped_btn),
    .car_ew   (car_ew),
    .ns_red   (ns_red),
    .ns_yellow(ns_yellow),
    .ns_green (ns_green),
    .ew_red   (ew_red),
    .ew_yellow(ew_yellow),
    .ew_green (ew_green),
    .walk     (walk),
    .ped_wait (ped_wait),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // state plus the seven lamps packed {state,nsr,nsy,nsg,ewr,ewy,ewg,walk}
  function automatic logic [9:0] lamps_for(input logic [2:0] s);
    logic nsg, nsy, ewg, ewy, wk;
    nsg = (s == 3'd0);
    nsy = (s == 3'd1);
    ewg = (s == 3'd3);
    ewy = (s == 3'd4);
    wk  = (s == 3'd6);
    return {s, ~(nsg | nsy), nsy, nsg, ~(ewg | ewy), ewy, ewg, wk};
  endfunction

  task automatic st(input string tag, input logic [2:0] s);
    check(tag, {22'd0, state_o, ns_red, ns_yellow, ns_green,
                ew_red, ew_yellow, ew_green, walk},
          {22'd0, lamps_for(s)});
  endtask

  initial begin
    rst_n   = 1'b0;
    ped_btn = 1'b0;
    car_ew  = 1'b0;
    tick(3);
    st("rst_hold", 3'd5);
    check("rst_pw", ped_wait, 0);

    // release: AR_B for 2 cycles then resting NSG
    rst_n = 1'b1;
    st("arb0", 3'd5);
    tick(1); st("arb1", 3'd5);
    tick(1); st("nsg_in", 3'd0);
    tick(20); st("nsg_rest", 3'd0);

    // car_ew held: max-out cycle
    car_ew = 1'b1;
    tick(2); st("nsg_sync", 3'd0);
    tick(1); st("nsy0", 3'd1);
    tick(2); st("nsy2", 3'd1);
    tick(1); st("ara0", 3'd2);
    tick(1); st("ara1", 3'd2);
    tick(1); st("ewg0", 3'd3);
    tick(9); st("ewg9", 3'd3);
    tick(1); st("ewy0", 3'd4);
    tick(2); st("ewy2", 3'd4);
    tick(1); st("arb_a", 3'd5);
    tick(1); st("arb_b", 3'd5);
    tick(1); st("nsg2_0", 3'd0);
    tick(3); st("nsg2_3", 3'd0);
    tick(1); st("nsy_r", 3'd1);
    tick(3); st("ara_r", 3'd2);
    tick(2); st("ewg_r", 3'd3);

    // gap-out: drop car on EWG entry
    car_ew = 1'b0;
    tick(3); st("gap3", 3'd3);
    tick(1); st("gap_ewy", 3'd4);
    tick(3); st("gap_arb", 3'd5);
    tick(2); st("gap_nsg", 3'd0);
    tick(10); st("gap_rest", 3'd0);

    // single ped pulse from resting NSG
    ped_btn = 1'b1;
    tick(1); ped_btn = 1'b0;
    tick(1); check("pw_e2", ped_wait, 0);
    tick(1); check("pw_e3", ped_wait, 1);
    st("p_nsg", 3'd0);
    tick(1); st("p_nsy", 3'd1);
    tick(3); st("p_ara", 3'd2);
    check("p_pw_ara", ped_wait, 1);
    tick(2); st("p_walk0", 3'd6);
    check("p_pw_walk", ped_wait, 0);
    tick(4); st("p_walk4", 3'd6);
    tick(1); st("p_arw", 3'd7);
    tick(2); st("p_nsg2", 3'd0);
    tick(8); st("p_rest", 3'd0);

    // held button with a second press inside WALK
    ped_btn = 1'b1;
    tick(3); check("h_pw", ped_wait, 1);
    tick(6); st("h_walk", 3'd6);
    ped_btn = 1'b0;
    tick(1); ped_btn = 1'b1;
    tick(4); st("h_arw", 3'd7);
    check("h_pw_arw", ped_wait, 0);
    tick(2); st("h_nsg", 3'd0);
    tick(12); st("h_rest", 3'd0);
    check("h_pw_rest", ped_wait, 0);
    ped_btn = 1'b0;
    tick(4);

    // async reset mid-EWG with a pending request
    car_ew = 1'b1;
    tick(3); st("r_nsy", 3'd1);
    tick(3); st("r_ara", 3'd2);
    tick(2); st("r_ewg", 3'd3);
    ped_btn = 1'b1;
    tick(1); ped_btn = 1'b0;
    tick(2); check("r_pw", ped_wait, 1);
    st("r_ewg3", 3'd3);
    car_ew = 1'b0;
    #2 rst_n = 1'b0;
    #1 st("r_async", 3'd5);
    check("r_pw0", ped_wait, 0);
    tick(2);
    #3 rst_n = 1'b1;
    tick(1); st("r_arb", 3'd5);
    tick(1); st("r_nsg", 3'd0);
    check("r_pw_end", ped_wait, 0);
    tick(6); st("r_rest", 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
